// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// Holds the FSM state encoding, the legal steps-per-clock set and sign correction.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned STEPS_LEGAL [3] = '{1, 2, 4};

  function automatic logic steps_legal(input int unsigned s);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (STEPS_LEGAL[i] == s) ok = 1'b1;
    end
    return ok;
  endfunction

  // Operates at the widest supported width; callers truncate, which is exact mod 2^WIDTH.
  function automatic logic [MAX_WIDTH-1:0] cond_neg(input logic [MAX_WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider: operands and start in, busy/done/results out.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
// Chained STEPS_PER_CYCLE deep inside seq_divider; no state, no handshake.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  // A set top bit means the shifted value cannot be below any WIDTH-bit divisor.
  assign q_bit   = rem_in[WIDTH] || (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider; done follows the accepting edge by WIDTH/STEPS_PER_CYCLE clocks (1 for b==0).
// start is only honoured while busy is low; requests during an operation are dropped.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic          clock,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!steps_legal(STEPS_PER_CYCLE) || (WIDTH % STEPS_PER_CYCLE) != 0 ||
      WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_params
    $error("seq_divider: illegal WIDTH/STEPS_PER_CYCLE combination");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;      // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_orig;
  logic             sign_q, sign_r, dbz_pend;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic             dbz_reg;

  logic             accept, last, b_zero, neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]         rem_c [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0]       dq_c  [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] qb;

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == LAST);
  assign b_zero = (bus.b == '0);
  assign neg_a  = bus.signed_mode && bus.a[WIDTH-1];
  assign neg_b  = bus.signed_mode && bus.b[WIDTH-1];
  assign a_mag  = WIDTH'(cond_neg(MAX_WIDTH'(bus.a), neg_a));
  assign b_mag  = WIDTH'(cond_neg(MAX_WIDTH'(bus.b), neg_b));

  assign rem_c[0] = rem;
  assign dq_c[0]  = dq;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[i]),
      .bit_in  (dq_c[i][WIDTH-1]),
      .divisor (dvs),
      .rem_out (rem_c[i+1]),
      .q_bit   (qb[i])
    );
    assign dq_c[i+1] = {dq_c[i][WIDTH-2:0], qb[i]};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? RUN : IDLE;
      RUN:        if (last || dbz_pend) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      dq       <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dbz_pend <= 1'b0;
      q_reg    <= '0;
      r_reg    <= '0;
      dbz_reg  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      dq       <= a_mag;
      rem      <= '0;
      dvs      <= b_mag;
      a_orig   <= bus.a;
      sign_q   <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      sign_r   <= neg_a;
      dbz_pend <= b_zero;
      dbz_reg  <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      dq  <= dq_c[STEPS_PER_CYCLE];
      rem <= rem_c[STEPS_PER_CYCLE];
      if (dbz_pend) begin
        q_reg   <= '1;
        r_reg   <= a_orig;
        dbz_reg <= 1'b1;
      end else if (last) begin
        q_reg <= WIDTH'(cond_neg(MAX_WIDTH'(dq_c[STEPS_PER_CYCLE]), sign_q));
        r_reg <= WIDTH'(cond_neg(MAX_WIDTH'(rem_c[STEPS_PER_CYCLE][WIDTH-1:0]), sign_r));
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: a 32-bit one-step instance and a 16-bit four-step instance.
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   t_acc32, t_acc16, lat, ndone;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  seq_divider_if #(.WIDTH(32)) i32 ();
  seq_divider_if #(.WIDTH(16)) i16 ();

  seq_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut32 (
    .clock (clock),
    .reset (reset),
    .bus   (i32.slave)
  );

  seq_divider #(.WIDTH(16), .STEPS_PER_CYCLE(4)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (i16.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic launch32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    @(negedge clock);
    i32.start = 1'b1; i32.a = a; i32.b = b; i32.signed_mode = sm;
    @(posedge clock); #1;
    t_acc32   = cyc;
    i32.start = 1'b0;
  endtask

  task automatic wait32(output int l);
    int guard = 0;
    while (i32.done !== 1'b1 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    l = cyc - t_acc32;
  endtask

  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    @(negedge clock);
    i16.start = 1'b1; i16.a = a; i16.b = b; i16.signed_mode = sm;
    @(posedge clock); #1;
    t_acc16   = cyc;
    i16.start = 1'b0;
  endtask

  task automatic wait16(output int l);
    int guard = 0;
    while (i16.done !== 1'b1 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    l = cyc - t_acc16;
  endtask

  initial begin
    reset = 1'b1;
    i32.start = 1'b0; i32.signed_mode = 1'b0; i32.a = '0; i32.b = '0;
    i16.start = 1'b0; i16.signed_mode = 1'b0; i16.a = '0; i16.b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, i32.busy}, 32'd0);
    check("rst_done", {31'd0, i32.done}, 32'd0);
    check("rst_q",    i32.q, 32'd0);
    check("rst_r",    i32.r, 32'd0);
    check("rst_dbz",  {31'd0, i32.div_by_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // unsigned 100 / 7
    launch32(32'd100, 32'd7, 1'b0);
    check("u_busy", {31'd0, i32.busy}, 32'd1);
    wait32(lat);
    check("u_lat", lat, 32'd32);
    check("u_q",   i32.q, 32'd14);
    check("u_r",   i32.r, 32'd2);
    check("u_dbz", {31'd0, i32.div_by_zero}, 32'd0);
    check("u_busy_done", {31'd0, i32.busy}, 32'd0);

    // signed -7 / 2 and 7 / -2
    launch32(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait32(lat);
    check("s1_q", i32.q, 32'hFFFF_FFFD);
    check("s1_r", i32.r, 32'hFFFF_FFFF);
    launch32(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait32(lat);
    check("s2_q", i32.q, 32'hFFFF_FFFD);
    check("s2_r", i32.r, 32'd1);

    // signed overflow MIN / -1
    launch32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait32(lat);
    check("ovf_q",   i32.q, 32'h8000_0000);
    check("ovf_r",   i32.r, 32'd0);
    check("ovf_dbz", {31'd0, i32.div_by_zero}, 32'd0);

    // unsigned full-range dividend
    launch32(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait32(lat);
    check("max_q", i32.q, 32'hFFFF_FFFF);
    check("max_r", i32.r, 32'd0);

    // divide by zero, then a normal op clears the flag
    launch32(32'h0000_1234, 32'd0, 1'b0);
    wait32(lat);
    check("dz_lat", lat, 32'd1);
    check("dz_q",   i32.q, 32'hFFFF_FFFF);
    check("dz_r",   i32.r, 32'h0000_1234);
    check("dz_dbz", {31'd0, i32.div_by_zero}, 32'd1);
    launch32(32'd100, 32'd7, 1'b0);
    check("dz_clear", {31'd0, i32.div_by_zero}, 32'd0);
    wait32(lat);
    check("dz_next_q", i32.q, 32'd14);

    // start while busy is ignored
    launch32(32'd1000, 32'd3, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    i32.start = 1'b1; i32.a = 32'd50; i32.b = 32'd5; i32.signed_mode = 1'b1;
    @(posedge clock); #1;
    i32.start = 1'b0;
    wait32(lat);
    check("ign_lat", lat, 32'd32);
    check("ign_q",   i32.q, 32'd333);
    check("ign_r",   i32.r, 32'd1);

    // reset mid-operation aborts without a done pulse
    launch32(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_busy", {31'd0, i32.busy}, 32'd0);
    check("abort_q",    i32.q, 32'd0);
    check("abort_r",    i32.r, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (i32.done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);

    // 16-bit, four quotient bits per clock, with back-to-back starts
    launch16(16'hFFFF, 16'h0010, 1'b0);
    wait16(lat);
    check("w16_lat", lat, 32'd4);
    check("w16_q",   {16'd0, i16.q}, 32'h0000_0FFF);
    check("w16_r",   {16'd0, i16.r}, 32'h0000_000F);
    launch16(16'd100, 16'd7, 1'b0);
    wait16(lat);
    check("b2b_lat", lat, 32'd4);
    check("b2b_q",   {16'd0, i16.q}, 32'd14);
    check("b2b_r",   {16'd0, i16.r}, 32'd2);
    launch16(16'hFF9C, 16'd7, 1'b1);
    wait16(lat);
    check("w16s_q", {16'd0, i16.q}, 32'h0000_FFF2);
    check("w16s_r", {16'd0, i16.r}, 32'h0000_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
